uart_tx_burst_reader: RTL and testbench
=======================================

// Module: uart_tx_burst_reader
// PURPOSE
//  UART transmitter that drains the pop side of multi_push_multi_pop_fifo.
//  It pops up to NO words in one cycle into a local buffer, then sends each
//  word as an 8N1-style frame on tx: start bit, W data bits LSB first, stop bit(s).
//  It is the reader/serializer at the tx end of the uart datapath.
// PARAMETERS
//  W            8    data bits per frame (equals FIFO word width)
//  NO           2    FIFO max pop per cycle; number of local buffer lanes
//  CLKS_PER_BIT 868  clk cycles per UART bit (100 MHz / 115200); must be >= 2
//  STOP_BITS    1    stop bits per frame; legal values 1 or 2
// PORTS
//  clk       in   1                     system clock, rising edge
//  rst       in   1                     asynchronous reset, active-high
//  enable    in   1                     permits new bursts; 0 blocks new pops only
//  can_pop   in   $clog2(NO+1)          words available from FIFO (<= NO)
//  pop       out  $clog2(NO+1)          words consumed this cycle
//  pop_data  in   [NO-1:0][W-1:0]       FIFO head words, lane 0 = oldest
//  tx        out  1                     serial line, idle = 1
//  busy      out  1                     1 while any burst word is untransmitted
// BEHAVIOUR
//  Reset: async; on assertion tx=1, busy=0, pop=0, state=IDLE, bit/baud/word
//   counters=0, buffer contents don't-care. Words already popped are dropped;
//   there is no resume after reset release.
//  FSM states: IDLE -> START -> DATA -> STOP -> (START | IDLE).
//  IDLE: tx=1, busy=0. If enable && can_pop!=0:
//   - pop=can_pop combinationally in that same cycle. pop is 0 in every other
//     state and cycle.
//   - Capture lanes 0..can_pop-1 of pop_data into the buffer.
//   - Load n_words=can_pop and word index=0. Go to START at the next edge.
//   pop_data is read in the same cycle as pop; no handshake latency.
//  START: tx=0 for exactly CLKS_PER_BIT cycles.
//  DATA: tx=buf[idx][b] for b=0..W-1 (LSB first), CLKS_PER_BIT cycles each.
//  STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. When it ends:
//   - idx+1 < n_words: idx++, go to START (frames back-to-back, no gap).
//   - else: go to IDLE.
//  Baud counter runs 0..CLKS_PER_BIT-1 and wraps at each bit boundary. It clears
//   on entry to START. Width $clog2(CLKS_PER_BIT).
//  Frame length = (1+W+STOP_BITS)*CLKS_PER_BIT cycles exactly.
//  busy: 1 from the first START cycle to the last STOP cycle of the burst.
//  Between bursts there is a minimum 1-cycle IDLE mark, so new pops are
//   evaluated only in IDLE.
//  enable=0 mid-burst: the burst completes normally; only the next pop is blocked.
//  can_pop changing during a burst is ignored. Buffer words are never re-popped.
//  can_pop > NO is illegal input (assertion); pop never exceeds NO.
//  tx is driven from a flop (glitch-free). The first start-bit edge appears one
//   clk after the pop cycle.
// TESTING  (W=8, NO=2, CLKS_PER_BIT=4, STOP_BITS=1 unless noted)
//  1 can_pop=1, pop_data[0]=0xA5, enable=1 -> pop=1 for one cycle; tx:
//    0 x4, then 1,0,1,0,0,1,0,1 x4 each, then 1 x4; busy high 40 cycles.
//  2 can_pop=2, lanes 0x01,0x80 -> single pop=2; two frames back-to-back
//    (80 cycles), 0x01 first; then busy=0 and >=1 idle cycle before the next pop.
//  3 enable=0, can_pop=2 for 20 cycles -> pop=0, tx=1, busy=0;
//    enable=1 -> pop=2 in that cycle.
//  4 rst pulsed during DATA bit 3 of the first of two words -> tx=1, busy=0
//    immediately; after release with can_pop=0, tx stays 1 and no frame resumes.
//  5 STOP_BITS=2, word 0xFF -> stop high 8 cycles; frame length 44 cycles.
//  6 Integrated with multi_push_multi_pop_fifo (NO=2): push 0x10..0x14 ->
//    pops of 2,2,1; tx decodes bytes 0x10..0x14 in order, none lost or duplicated.

Source files
------------

// File: rtl/uart_tx_burst_reader.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_burst_reader
// Brief   : Pops up to NO FIFO words per burst and sends each one as a UART
//           frame (start, W data bits LSB first, STOP_BITS stop bits).
// Rev     : 1.0
// ============================================================================
module uart_tx_burst_reader #(
  parameter int W            = 8,
  parameter int NO           = 2,
  parameter int CLKS_PER_BIT = 868,
  parameter int STOP_BITS    = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [$clog2(NO+1)-1:0] can_pop,
  output logic [$clog2(NO+1)-1:0] pop,
  input  logic [NO-1:0][W-1:0]    pop_data,
  output logic                    tx,
  output logic                    busy
);

  localparam int CNT_W  = $clog2(NO + 1);
  localparam int IDX_W  = (NO > 1) ? $clog2(NO) : 1;
  localparam int BIT_W  = (W > 1) ? $clog2(W) : 1;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0]  c_NO       = CNT_W'(NO);
  localparam logic [BAUD_W-1:0] c_BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  c_BIT_MAX  = BIT_W'(W - 1);
  localparam logic              c_STOP_MAX = (STOP_BITS == 2);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t               state_q;
  logic [BAUD_W-1:0]    baud_q;
  logic [BIT_W-1:0]     bit_q;
  logic                 stop_q;
  logic [CNT_W-1:0]     idx_q;
  logic [CNT_W-1:0]     nwords_q;
  logic [W-1:0]         buf_q [NO];
  logic                 tx_q;
  logic                 busy_q;

  logic [CNT_W-1:0]     w_pop_amt;
  logic                 w_fire;
  logic                 w_bit_end;
  logic [BIT_W-1:0]     w_next_bit;
  logic [CNT_W-1:0]     w_next_idx;
  logic                 w_more;
  logic [W-1:0]         w_cur_word;

  // Illegal can_pop values are clamped so pop can never exceed NO.
  assign w_pop_amt  = (can_pop > c_NO) ? c_NO : can_pop;
  assign w_fire     = !rst && enable && (state_q == S_IDLE) && (can_pop != '0);
  assign pop        = w_fire ? w_pop_amt : '0;

  assign w_bit_end  = (baud_q == c_BAUD_MAX);
  assign w_next_bit = bit_q + 1'b1;
  assign w_next_idx = idx_q + 1'b1;
  assign w_more     = (w_next_idx < nwords_q);
  assign w_cur_word = buf_q[idx_q[IDX_W-1:0]];

  assign tx   = tx_q;
  assign busy = busy_q;

  always_ff @(posedge clk) begin
    for (int l = 0; l < NO; l++) begin
      if (w_fire && (l < int'(w_pop_amt))) begin
        buf_q[l] <= pop_data[l];
      end
    end
  end

  // tx_q is loaded with the level of the upcoming bit so the line comes from a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      stop_q   <= 1'b0;
      idx_q    <= '0;
      nwords_q <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      if (state_q != S_IDLE) begin
        baud_q <= w_bit_end ? '0 : baud_q + 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (w_fire) begin
            nwords_q <= w_pop_amt;
            idx_q    <= '0;
            baud_q   <= '0;
            tx_q     <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= S_START;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            bit_q   <= '0;
            tx_q    <= w_cur_word[0];
            state_q <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            if (bit_q == c_BIT_MAX) begin
              stop_q  <= 1'b0;
              tx_q    <= 1'b1;
              state_q <= S_STOP;
            end else begin
              bit_q <= w_next_bit;
              tx_q  <= w_cur_word[w_next_bit];
            end
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            if (stop_q == c_STOP_MAX) begin
              if (w_more) begin
                idx_q   <= w_next_idx;
                tx_q    <= 1'b0;
                state_q <= S_START;
              end else begin
                tx_q    <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= S_IDLE;
              end
            end else begin
              stop_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  a_can_pop_legal: assert property (@(posedge clk) disable iff (rst) can_pop <= c_NO);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_burst_reader.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_tx_burst_reader
// Brief   : Randomized and directed bench against a frame-level line model.
// Rev     : 1.0
// ============================================================================
module tb_uart_tx_burst_reader;

  localparam int W   = 8;
  localparam int NO  = 2;
  localparam int CPB = 4;
  localparam int CW  = $clog2(NO + 1);

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 en1, en2;
  logic [CW-1:0]        cp1, cp2, pop1, pop2;
  logic [NO-1:0][W-1:0] pd1, pd2;
  logic                 tx1, tx2, busy1, busy2;

  always #5 clk = ~clk;

  uart_tx_burst_reader #(.W(W), .NO(NO), .CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut1 (
    .clk(clk), .rst(rst), .enable(en1), .can_pop(cp1), .pop(pop1),
    .pop_data(pd1), .tx(tx1), .busy(busy1)
  );

  uart_tx_burst_reader #(.W(W), .NO(NO), .CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .enable(en2), .can_pop(cp2), .pop(pop2),
    .pop_data(pd2), .tx(tx2), .busy(busy2)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  // Model: expected line level for every future cycle of the running burst.
  bit                   exq[$];
  logic [W-1:0]         fifo[$];
  bit                   fifo_mode = 1'b0;
  int                   sel = 1;
  logic                 cur_en = 1'b0;
  int                   cur_cp = 0;
  logic [NO-1:0][W-1:0] cur_pd = '0;
  int                   busy_cycles = 0;
  int                   pop_log[$];

  task automatic push_frame(input logic [W-1:0] d, input int sb);
    bit lvl;
    for (int b = 0; b < 1 + W + sb; b++) begin
      if (b == 0)      lvl = 1'b0;
      else if (b <= W) lvl = d[b-1];
      else             lvl = 1'b1;
      repeat (CPB) exq.push_back(lvl);
    end
  endtask

  task automatic step();
    int   exp_pop, g_pop;
    logic g_tx, g_busy;
    @(posedge clk);
    #1;
    if (fifo_mode) begin
      cur_cp = (fifo.size() < NO) ? fifo.size() : NO;
      cur_pd = '0;
      for (int k = 0; k < cur_cp; k++) cur_pd[k] = fifo[k];
    end
    en1 = (sel == 1) && cur_en;
    en2 = (sel == 2) && cur_en;
    cp1 = (sel == 1) ? CW'(cur_cp) : '0;
    cp2 = (sel == 2) ? CW'(cur_cp) : '0;
    pd1 = cur_pd;
    pd2 = cur_pd;
    @(negedge clk);
    g_tx   = (sel == 1) ? tx1 : tx2;
    g_busy = (sel == 1) ? busy1 : busy2;
    g_pop  = (sel == 1) ? int'(pop1) : int'(pop2);
    exp_pop = (exq.size() == 0 && cur_en && cur_cp != 0) ? cur_cp : 0;
    check_eq("tx",   g_tx,   (exq.size() > 0) ? int'(exq[0]) : 1);
    check_eq("busy", g_busy, (exq.size() > 0) ? 1 : 0);
    check_eq("pop",  g_pop,  exp_pop);
    check_eq("other_tx",  (sel == 1) ? tx2 : tx1, 1);
    check_eq("other_pop", (sel == 1) ? int'(pop2) : int'(pop1), 0);
    if (g_busy) busy_cycles++;
    if (g_pop != 0) pop_log.push_back(g_pop);
    if (exq.size() > 0) void'(exq.pop_front());
    for (int k = 0; k < exp_pop; k++) begin
      push_frame(cur_pd[k], sel);
      if (fifo_mode) void'(fifo.pop_front());
    end
  endtask

  task automatic run_random(input int n);
    for (int i = 0; i < n; i++) begin
      cur_en = ($urandom_range(0, 3) != 0);
      cur_cp = $urandom_range(0, NO);
      for (int k = 0; k < NO; k++) cur_pd[k] = W'($urandom);
      step();
    end
    cur_cp = 0;
    repeat (2 * NO * (1 + W + 2) * CPB + 4) step();
  endtask

  initial begin
    rst = 1'b1;
    en1 = 1'b1; en2 = 1'b1; cp1 = 2; cp2 = 2;
    pd1 = {8'h22, 8'h11}; pd2 = {8'h22, 8'h11};
    #12;
    check_eq("rst_tx1", tx1, 1);
    check_eq("rst_busy1", busy1, 0);
    check_eq("rst_pop1", pop1, 0);
    check_eq("rst_tx2", tx2, 1);
    check_eq("rst_pop2", pop2, 0);
    en1 = 1'b0; en2 = 1'b0; cp1 = 0; cp2 = 0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Single word 0xA5
    sel = 1; cur_en = 1'b1; cur_cp = 1; cur_pd = '0; cur_pd[0] = 8'hA5;
    pop_log.delete(); busy_cycles = 0;
    step();
    cur_cp = 0;
    repeat (45) step();
    check_eq("t1_busy_len", busy_cycles, 40);
    check_eq("t1_pop_events", pop_log.size(), 1);
    if (pop_log.size() > 0) check_eq("t1_pop_amt", pop_log[0], 1);

    // Two-word burst, can_pop held during the burst
    cur_cp = 2; cur_pd[0] = 8'h01; cur_pd[1] = 8'h80;
    pop_log.delete(); busy_cycles = 0;
    repeat (81) step();
    check_eq("t2_busy_len", busy_cycles, 80);
    check_eq("t2_pop_events", pop_log.size(), 1);
    step();
    check_eq("t2_repop_after_gap", pop_log.size(), 2);
    cur_cp = 0;
    repeat (85) step();

    // Enable low blocks pops
    cur_en = 1'b0; cur_cp = 2; pop_log.delete(); busy_cycles = 0;
    repeat (20) step();
    check_eq("t3_no_pop", pop_log.size(), 0);
    check_eq("t3_no_busy", busy_cycles, 0);
    cur_en = 1'b1;
    step();
    check_eq("t3_pop_on_enable", pop_log.size(), 1);
    cur_cp = 0;
    repeat (85) step();

    // Reset during data bit 3 of the first word
    cur_cp = 2; cur_pd[0] = 8'hC3; cur_pd[1] = 8'h5A;
    step();
    cur_cp = 0;
    repeat (17) step();
    check_eq("t4_pre_rst_tx", tx1, 0);
    rst = 1'b1;
    #1;
    check_eq("t4_rst_tx", tx1, 1);
    check_eq("t4_rst_busy", busy1, 0);
    check_eq("t4_rst_pop", pop1, 0);
    exq.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    busy_cycles = 0;
    repeat (40) step();
    check_eq("t4_no_resume", busy_cycles, 0);

    // FIFO-fed stream 0x10..0x14
    for (int b = 8'h10; b <= 8'h14; b++) fifo.push_back(W'(b));
    fifo_mode = 1'b1; pop_log.delete();
    repeat (215) step();
    fifo_mode = 1'b0; cur_cp = 0;
    check_eq("t6_pop_events", pop_log.size(), 3);
    if (pop_log.size() == 3) begin
      check_eq("t6_pop0", pop_log[0], 2);
      check_eq("t6_pop1", pop_log[1], 2);
      check_eq("t6_pop2", pop_log[2], 1);
    end

    run_random(1500);

    // Two stop bits, word 0xFF
    sel = 2; cur_en = 1'b1; cur_cp = 1; cur_pd[0] = 8'hFF; busy_cycles = 0;
    step();
    cur_cp = 0;
    repeat (50) step();
    check_eq("t5_frame_len", busy_cycles, 44);

    run_random(600);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
